// File: rtl/frame_writer.sv
// frame_writer: emits header / incrementing payload / optional XOR checksum frames
// into a word buffer, throttled by buffer_full. Checksum enabled by `FRAME_WRITER_CHECKSUM_EN.
module frame_writer #(
  parameter logic [7:0] SYNC = 8'hA5
) (
  input  logic        clk_1,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  frame_len,
  input  logic [15:0] seed,
  input  logic        buffer_full,
  output logic [15:0] data_1,
  output logic        data_1_en,
  output logic        busy,
  output logic        done,
  output logic [7:0]  frame_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
`ifdef FRAME_WRITER_CHECKSUM_EN
    , CHECK = 2'd3
`endif
  } state_t;

  state_t      state;
  logic [7:0]  remain;
  logic [15:0] next_word;
  logic        last_payload;
  logic        final_word;

`ifdef FRAME_WRITER_CHECKSUM_EN
  logic [15:0] csum;
  logic [15:0] csum_next;
  assign csum_next = csum ^ data_1;
`endif

  // Every non-IDLE state holds a pending word; the strobe reacts to full with no lag.
  assign busy      = (state != IDLE);
  assign data_1_en = busy & ~buffer_full;

  // The word being accepted this cycle is the last one before the trailer (or end of frame).
  assign last_payload = ((state == HEADER) && (remain == 8'd0)) ||
                        ((state == PAYLOAD) && (remain == 8'd1));

  always_comb begin
    // NOTE: combinational signals get a default first so no latch is inferred.
    final_word = 1'b0;
`ifdef FRAME_WRITER_CHECKSUM_EN
    if (data_1_en && (state == CHECK)) final_word = 1'b1;
`else
    if (data_1_en && last_payload) final_word = 1'b1;
`endif
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_1) begin
    if (!rst_n) begin
      state       <= IDLE;
      data_1      <= '0;
      remain      <= '0;
      next_word   <= '0;
      done        <= 1'b0;
      frame_count <= '0;
`ifdef FRAME_WRITER_CHECKSUM_EN
      csum        <= '0;
`endif
    end else begin
      done <= final_word;
      if (final_word) begin
        frame_count <= frame_count + 8'd1;
        state       <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state     <= HEADER;
              data_1    <= {SYNC, frame_len};
              remain    <= frame_len;
              next_word <= seed;
`ifdef FRAME_WRITER_CHECKSUM_EN
              csum      <= '0;
`endif
            end
          end
          HEADER, PAYLOAD: begin
            if (data_1_en) begin
`ifdef FRAME_WRITER_CHECKSUM_EN
              csum <= csum_next;
`endif
              if (last_payload) begin
`ifdef FRAME_WRITER_CHECKSUM_EN
                state  <= CHECK;
                data_1 <= csum_next;
`endif
              end else begin
                // remain only counts down on payload words; the header leaves it at frame_len.
                if (state == PAYLOAD) remain <= remain - 8'd1;
                state     <= PAYLOAD;
                data_1    <= next_word;
                next_word <= next_word + 16'd1;
              end
            end
          end
          default: state <= state;
        endcase
      end
    end
  end

endmodule

// File: doc/frame_writer.md
# frame_writer

Single-clock frame transmitter on the write side of the 8-entry dual-clock word buffer. It runs in the `clk_1` domain. On a start pulse it emits one frame of 16-bit words into the buffer's `data_1`/`data_1_en` write port: a header, an incrementing payload, and an optional XOR checksum. Emission is throttled by `buffer_full`, so no word is ever offered while the buffer reports full. It replaces ad-hoc testbench stimulus as the buffer's producer and pairs with the buffer's reader on `clk_2`.

## Interface
- `SYNC`, default 8'hA5: upper byte of every header word.
- `clk_1`  in  1: sole clock; all state changes on its rising edge.
- `rst_n`  in  1: synchronous, active-low reset, sampled on rising `clk_1`.
- `start`  in  1: begin a frame. Sampled only in IDLE; ignored otherwise.
- `frame_len`  in  8: payload word count, captured at start; 0 is legal.
- `seed`  in  16: first payload value, captured at start.
- `buffer_full`  in  1: buffer full flag; no write is issued while it is high.
- `data_1`  out  16: current frame word (registered).
- `data_1_en`  out  1: write strobe; a word is accepted in every cycle it is high.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse after the last word of a frame is accepted.
- `frame_count`  out  8: completed frames, modulo 256.

## Operation
- States:
  - IDLE -> HEADER on `start`.
  - HEADER -> PAYLOAD if the captured length > 0, else -> CHECK.
  - PAYLOAD -> CHECK after the last payload word.
  - CHECK -> IDLE.
  - A state advances only in a cycle where `data_1_en` is high.
- Word pending: any state other than IDLE holds one pending word in `data_1`.
- Write strobe: `data_1_en = pending & ~buffer_full`. This is combinational from the registered state and `buffer_full`, so the block reacts to full with zero lag.
- Header word: `{SYNC, frame_len}`.
- Payload word k (k = 0..len-1): `seed + k`, modulo 2^16. 16'hFFFF wraps to 16'h0000.
- Payload counter: internal 8-bit down-counter loaded with `frame_len` at start; PAYLOAD exits when it reaches 1 and that word is accepted.
- Checksum word: 16-bit XOR of the header and all payload words, accumulated as each word is accepted.
- `done` and the `frame_count` increment both occur on the edge that accepts the final word. `done` is high during the following cycle, when the state is already IDLE.
- `start` in the same cycle `done` is high is accepted, since the state is IDLE.
- `start` while `busy` is dropped; it is not queued.
- `frame_len`/`seed` changes after capture have no effect on the frame in flight.
- Reset (`rst_n` low at an edge), including mid-frame:
  - Partial frame abandoned; state to IDLE.
  - `data_1` = 0, `data_1_en` = 0, `busy` = 0, `done` = 0, `frame_count` = 0, checksum accumulator = 0.

## Timing
- Start to first word: `start` sampled at edge t. From t+1, `data_1` holds the header and `data_1_en` is high unless `buffer_full`.
- Throughput: one word per cycle while `buffer_full` is low.
- Frame duration: minimum len+2 cycles with checksum, len+1 without.
- Stall: while `buffer_full` is high, `data_1` holds its value and the state freezes. Resuming neither loses nor duplicates a word.
- `done` latency: `done` is high in the cycle after the final accepted word.
- Restart: earliest next header is one cycle after `done`, i.e. with `start` held high there is zero idle gap beyond the IDLE cycle.

## Configuration
- Macro: `FRAME_WRITER_CHECKSUM_EN`.
- Defined: CHECK state present; the checksum word is appended to every frame.
- Undefined:
  - CHECK and the XOR accumulator are not compiled.
  - The final payload word (or the header, when len = 0) completes the frame: `done` pulses and `frame_count` increments on its acceptance.

## Test plan
- Basic frame (macro defined): `start`, len=3, seed=16'h0010, `buffer_full`=0 -> words A503, 0010, 0011, 0012, A510 on 5 consecutive cycles; `done` on the 6th; `frame_count`=1.
- Empty payload: len=0 -> A500 then A500 (checksum), then `done`. With the macro undefined -> single word A500, then `done`.
- Stall: `buffer_full` held high for 4 cycles during payload -> `data_1_en` low and `data_1` stable for those 4 cycles; the full sequence completes intact with no gaps or repeats.
- Wrap: seed=16'hFFFF, len=2 -> payload FFFF, 0000; checksum A502^FFFF^0000 = 5AFD.
- Reset mid-frame: `rst_n` low for one edge after the second payload word -> all outputs 0 next cycle; a new `start` produces a fresh header.
- Busy `start`, then back-to-back frames: `start` pulsed mid-frame is ignored (exactly one frame emitted). `start` held high runs two frames back-to-back -> `frame_count`=2.
